// File: rtl/iob_axis_pkt_arbiter_pkg.sv
// Shared types and constants for the packet-granular AXI-Stream arbiter.
package iob_axis_pkt_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } arb_state_t;

    localparam int MAX_LEN_DEFAULT = 256;

    // A disabled limit (0) still needs a 1-bit counter to keep the declaration legal.
    function automatic int cnt_width(input int max_len);
        return (max_len > 0) ? $clog2(max_len + 1) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_rr_arbiter_sel.sv
// Combinational round-robin selector: first requester after ptr_i, as one-hot and index.
module iob_rr_arbiter_sel
    import iob_axis_pkt_arbiter_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_IN-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_IN-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    logic [N_IN-1:0]  w_rot;
    logic [IDX_W-1:0] w_off;
    logic             w_hit;

    // Rotate so bit 0 is the port right after the last served one, then take the lowest set bit.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_rot[i] = req_i[IDX_W'((int'(ptr_i) + 1 + i) % N_IN)];
        end
        w_off = '0;
        w_hit = 1'b0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_hit = 1'b1;
                w_off = IDX_W'(i);
            end
        end
    end

    always_comb begin
        idx_o = IDX_W'((int'(ptr_i) + 1 + int'(w_off)) % N_IN);
        vld_o = w_hit;
        gnt_o = '0;
        gnt_o[idx_o] = w_hit;
    end

endmodule

// File: rtl/iob_axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream output among N_IN sources,
// with an optional beat limit that forces tlast on runaway packets.
module iob_axis_pkt_arbiter
    import iob_axis_pkt_arbiter_pkg::*;
#(
    parameter int N_IN    = 2,
    parameter int TDATA_W = 8,
    parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    cke_i,
    input  logic                    arst_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [N_IN*TDATA_W-1:0] s_tdata_i,
    input  logic [N_IN-1:0]         s_tvalid_i,
    input  logic [N_IN-1:0]         s_tlast_i,
    output logic [N_IN-1:0]         s_tready_o,
    output logic [TDATA_W-1:0]      m_tdata_o,
    output logic                    m_tvalid_o,
    output logic                    m_tlast_o,
    input  logic                    m_tready_i,
    output logic [N_IN-1:0]         grant_o,
    output logic                    busy_o,
    output logic                    trunc_o
);

    localparam int               IDX_W    = idx_width(N_IN);
    localparam int               CNT_W    = cnt_width(MAX_LEN);
    localparam bit               TRUNC_EN = (MAX_LEN > 0);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((MAX_LEN > 0) ? MAX_LEN - 1 : 0);
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_IN - 1);

    arb_state_t       r_state;
    logic [N_IN-1:0]  r_grant;
    logic [IDX_W-1:0] r_gidx;
    logic [IDX_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_trunc;

    logic [N_IN-1:0]  w_sel_gnt;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_sel_vld;
    logic             w_busy;
    logic             w_src_tlast;
    logic             w_force;
    logic             w_xfer;
    logic             w_eop;

    iob_rr_arbiter_sel #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_sel (
        .req_i (s_tvalid_i),
        .ptr_i (r_ptr),
        .gnt_o (w_sel_gnt),
        .idx_o (w_sel_idx),
        .vld_o (w_sel_vld)
    );

    // Pass-through of the granted port; grant is all-zero when idle, which closes every tready.
    assign w_busy      = (r_state == ST_PKT);
    assign w_src_tlast = s_tlast_i[r_gidx];
    assign w_force     = TRUNC_EN && (r_beat_cnt == LAST_CNT);
    assign m_tvalid_o  = w_busy & s_tvalid_i[r_gidx];
    assign m_tlast_o   = w_busy & (w_src_tlast | w_force);
    assign m_tdata_o   = w_busy ? s_tdata_i[int'(r_gidx)*TDATA_W +: TDATA_W] : '0;
    assign s_tready_o  = r_grant & {N_IN{m_tready_i}};
    assign w_xfer      = m_tvalid_o & m_tready_i;
    assign w_eop       = w_xfer & m_tlast_o;

    assign grant_o = r_grant;
    assign busy_o  = w_busy;
    assign trunc_o = r_trunc;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_ptr      <= PTR_RST;
            r_beat_cnt <= '0;
            r_trunc    <= 1'b0;
        end else if (cke_i) begin
            if (rst_i) begin
                r_state    <= ST_IDLE;
                r_grant    <= '0;
                r_gidx     <= '0;
                r_ptr      <= PTR_RST;
                r_beat_cnt <= '0;
                r_trunc    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (en_i && w_sel_vld) begin
                            r_state <= ST_PKT;
                            r_grant <= w_sel_gnt;
                            r_gidx  <= w_sel_idx;
                        end
                    end
                    ST_PKT: begin
                        if (w_eop) begin
                            r_state    <= ST_IDLE;
                            r_ptr      <= r_gidx;
                            r_beat_cnt <= '0;
                            r_grant    <= '0;
                            // A limit-induced end while the source still had more to send.
                            if (w_force && !w_src_tlast) begin
                                r_trunc <= 1'b1;
                            end
                        end else if (w_xfer) begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iob_axis_pkt_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a packet-level reference model.
module tb_iob_axis_pkt_arbiter;

    localparam int N_IN    = 3;
    localparam int TDATA_W = 8;
    localparam int MAX_LEN = 5;
    localparam int QD      = 1024;

    logic                    clk = 1'b0;
    logic                    cke_i, arst_i, rst_i, en_i;
    logic [N_IN*TDATA_W-1:0] s_tdata_i;
    logic [N_IN-1:0]         s_tvalid_i, s_tlast_i, s_tready_o;
    logic [TDATA_W-1:0]      m_tdata_o;
    logic                    m_tvalid_o, m_tlast_o, m_tready_i;
    logic [N_IN-1:0]         grant_o;
    logic                    busy_o, trunc_o;

    always #5 clk = ~clk;

    iob_axis_pkt_arbiter #(
        .N_IN    (N_IN),
        .TDATA_W (TDATA_W),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk_i      (clk),
        .cke_i      (cke_i),
        .arst_i     (arst_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .s_tdata_i  (s_tdata_i),
        .s_tvalid_i (s_tvalid_i),
        .s_tlast_i  (s_tlast_i),
        .s_tready_o (s_tready_o),
        .m_tdata_o  (m_tdata_o),
        .m_tvalid_o (m_tvalid_o),
        .m_tlast_o  (m_tlast_o),
        .m_tready_i (m_tready_i),
        .grant_o    (grant_o),
        .busy_o     (busy_o),
        .trunc_o    (trunc_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Source packet storage: {tlast, tdata} per beat.
    logic [TDATA_W:0] src_mem [N_IN][QD];
    int               head [N_IN];
    int               tail [N_IN];
    logic [N_IN-1:0]  gate;
    logic [TDATA_W:0] out_q [$];

    // Reference model: who owns the output (-1 = nobody), who was served last, beats so far.
    int m_owner, m_last, m_cnt;
    bit m_trunc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N_IN - 1;
        m_cnt   = 0;
        m_trunc = 1'b0;
    endtask

    task automatic push_beat(input int k, input logic [TDATA_W-1:0] d, input logic l);
        if (tail[k] < QD) begin
            src_mem[k][tail[k]] = {l, d};
            tail[k]++;
        end
    endtask

    task automatic clear_srcs();
        for (int k = 0; k < N_IN; k++) begin
            head[k] = 0;
            tail[k] = 0;
        end
    endtask

    task automatic drive_srcs();
        for (int k = 0; k < N_IN; k++) begin
            if (head[k] < tail[k]) begin
                s_tvalid_i[k]                     = gate[k];
                s_tlast_i[k]                      = src_mem[k][head[k]][TDATA_W];
                s_tdata_i[k*TDATA_W +: TDATA_W]   = src_mem[k][head[k]][TDATA_W-1:0];
            end else begin
                s_tvalid_i[k]                     = 1'b0;
                s_tlast_i[k]                      = 1'($urandom_range(0, 1));
                s_tdata_i[k*TDATA_W +: TDATA_W]   = TDATA_W'($urandom);
            end
        end
    endtask

    // One clock: drive at the falling edge, check 1 ns later, advance the model, wait for the next falling edge.
    task automatic step();
        logic [N_IN-1:0]    e_grant, e_tready;
        logic               e_busy, e_tvalid, e_tlast, e_force;
        logic [TDATA_W-1:0] e_tdata;
        bit                 found;
        drive_srcs();
        #1;
        e_busy   = (m_owner >= 0);
        e_grant  = '0;
        e_tready = '0;
        e_tvalid = 1'b0;
        e_tlast  = 1'b0;
        e_tdata  = '0;
        e_force  = (MAX_LEN != 0) && (m_cnt == MAX_LEN - 1);
        if (e_busy) begin
            e_grant[m_owner]  = 1'b1;
            e_tvalid          = s_tvalid_i[m_owner];
            e_tlast           = s_tlast_i[m_owner] || e_force;
            e_tdata           = s_tdata_i[m_owner*TDATA_W +: TDATA_W];
            e_tready[m_owner] = m_tready_i;
        end
        check_eq("grant",  32'(grant_o),    32'(e_grant));
        check_eq("busy",   32'(busy_o),     32'(e_busy));
        check_eq("tvalid", 32'(m_tvalid_o), 32'(e_tvalid));
        check_eq("tlast",  32'(m_tlast_o),  32'(e_tlast));
        check_eq("tdata",  32'(m_tdata_o),  32'(e_tdata));
        check_eq("tready", 32'(s_tready_o), 32'(e_tready));
        check_eq("trunc",  32'(trunc_o),    32'(m_trunc));

        if (cke_i) begin
            for (int k = 0; k < N_IN; k++) begin
                if (s_tvalid_i[k] && s_tready_o[k]) head[k]++;
            end
            if (m_tvalid_o && m_tready_i) out_q.push_back({m_tlast_o, m_tdata_o});
        end

        if (cke_i) begin
            if (rst_i) begin
                model_reset();
            end else if (m_owner < 0) begin
                found = 1'b0;
                if (en_i) begin
                    for (int i = 1; i <= N_IN; i++) begin
                        if (!found && s_tvalid_i[(m_last + i) % N_IN]) begin
                            found   = 1'b1;
                            m_owner = (m_last + i) % N_IN;
                        end
                    end
                end
            end else if (e_tvalid && m_tready_i) begin
                m_cnt++;
                if (e_tlast) begin
                    if (e_force && !s_tlast_i[m_owner]) m_trunc = 1'b1;
                    m_last  = m_owner;
                    m_owner = -1;
                    m_cnt   = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        cke_i      = 1'b1;
        arst_i     = 1'b1;
        rst_i      = 1'b0;
        en_i       = 1'b1;
        m_tready_i = 1'b1;
        s_tvalid_i = '1;
        s_tlast_i  = '1;
        s_tdata_i  = '1;
        gate       = '1;
        clear_srcs();
        model_reset();

        // Reset holds everything quiet even with every source requesting.
        repeat (3) @(negedge clk);
        check_eq("rst_grant",  32'(grant_o),    32'd0);
        check_eq("rst_busy",   32'(busy_o),     32'd0);
        check_eq("rst_tvalid", 32'(m_tvalid_o), 32'd0);
        check_eq("rst_tdata",  32'(m_tdata_o),  32'd0);
        check_eq("rst_tready", 32'(s_tready_o), 32'd0);
        check_eq("rst_trunc",  32'(trunc_o),    32'd0);
        arst_i = 1'b0;

        // Single source, three beats on port 1.
        push_beat(1, 8'hA1, 1'b0);
        push_beat(1, 8'hA2, 1'b0);
        push_beat(1, 8'hA3, 1'b1);
        repeat (6) step();
        check_eq("single_len", 32'(out_q.size()), 32'd3);
        if (out_q.size() == 3) begin
            check_eq("single_b0", 32'(out_q[0]), 32'h0A1);
            check_eq("single_b1", 32'(out_q[1]), 32'h0A2);
            check_eq("single_b2", 32'(out_q[2]), 32'h1A3);
        end
        check_eq("single_idle", 32'(busy_o), 32'd0);

        // Runaway packet on port 0: 7 beats against a 5-beat limit.
        out_q.delete();
        for (int i = 0; i < 7; i++) push_beat(0, TDATA_W'(8'hD0 + i), (i == 6));
        repeat (14) step();
        check_eq("trunc_len", 32'(out_q.size()), 32'd7);
        if (out_q.size() == 7) begin
            for (int i = 0; i < 7; i++) begin
                check_eq("trunc_beat", 32'(out_q[i]), 32'({(i == 4 || i == 6), TDATA_W'(8'hD0 + i)}));
            end
        end
        check_eq("trunc_flag", 32'(trunc_o), 32'd1);

        // Soft reset on beat 2 of a 5-beat packet.
        for (int k = 0; k < N_IN; k++) begin
            for (int i = 0; i < 5; i++) push_beat(k, TDATA_W'(16 * k + i), (i == 4));
        end
        repeat (2) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check_eq("srst_busy",   32'(busy_o),     32'd0);
        check_eq("srst_tvalid", 32'(m_tvalid_o), 32'd0);
        check_eq("srst_tready", 32'(s_tready_o), 32'd0);
        check_eq("srst_trunc",  32'(trunc_o),    32'd0);
        clear_srcs();
        for (int k = 0; k < N_IN; k++) push_beat(k, TDATA_W'(8'h50 + k), 1'b1);
        step();
        check_eq("srst_prio", 32'(grant_o), 32'b001);
        repeat (8) step();

        // en_i dropped mid-packet: packet finishes, pending port 1 waits.
        push_beat(0, 8'h61, 1'b0);
        push_beat(0, 8'h62, 1'b0);
        push_beat(0, 8'h63, 1'b1);
        push_beat(1, 8'h71, 1'b1);
        step();
        en_i = 1'b0;
        repeat (6) step();
        check_eq("en_idle",  32'(busy_o),  32'd0);
        check_eq("en_grant", 32'(grant_o), 32'd0);
        en_i = 1'b1;
        step();
        check_eq("en_resume", 32'(grant_o), 32'b010);
        repeat (4) step();

        // Randomized traffic with stalls, clock-enable gaps, backpressure and rare soft resets.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N_IN; k++) begin
                if (head[k] >= tail[k]) begin
                    head[k] = 0;
                    tail[k] = 0;
                    if ($urandom_range(0, 2) == 0) begin
                        int len;
                        len = int'($urandom_range(1, 8));
                        for (int i = 0; i < len; i++) push_beat(k, TDATA_W'($urandom), (i == len - 1));
                    end
                end
                gate[k] = ($urandom_range(0, 9) != 0);
            end
            en_i       = ($urandom_range(0, 7) != 0);
            cke_i      = ($urandom_range(0, 9) != 0);
            m_tready_i = cke_i && ($urandom_range(0, 3) != 0);
            rst_i      = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
